sp_ctrl_seq: RTL

//  Instruction-level sequencer that drives the control inputs of one SPCore: x/y/z, I, aluc, s2, reg_we.

---
 rtl/sp_ctrl_seq_pkg.sv | 71 +++++++
 rtl/sp_ctrl_seq_if.sv | 34 +++
 rtl/sp_instr_decode.sv | 38 +++
 rtl/sp_ctrl_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sp_ctrl_seq_pkg.sv
// Shared constants for the SPCore instruction sequencer: opcodes, ALU/mux codes,
// instruction field offsets and the opcode-to-ALU-op map.
package sp_ctrl_seq_pkg;

  localparam int GUARD_BIT = 31;
  localparam int OPC_LSB   = 27;
  localparam int X_LSB     = 23;
  localparam int Y_LSB     = 19;
  localparam int Z_LSB     = 15;
  localparam int I_LSB     = 0;

  localparam int OPC_W  = 4;
  localparam int ALUC_W = 4;
  localparam int S2_W   = 2;

  typedef enum logic [OPC_W-1:0] {
    NOP   = 4'd0,
    LOADI = 4'd1,
    ADD   = 4'd2,
    MUL   = 4'd3,
    MAD   = 4'd4,
    LOADC = 4'd5,
    CLEAR = 4'd6,
    INC   = 4'd7,
    SETP  = 4'd8,
    LOAD  = 4'd9,
    STORE = 4'd10,
    HALT  = 4'd11
  } opcode_e;

  localparam logic [ALUC_W-1:0] ALUC_ADD   = 4'd0;
  localparam logic [ALUC_W-1:0] ALUC_MUL   = 4'd1;
  localparam logic [ALUC_W-1:0] ALUC_MAD   = 4'd2;
  localparam logic [ALUC_W-1:0] ALUC_LOADC = 4'd3;
  localparam logic [ALUC_W-1:0] ALUC_CLEAR = 4'd4;
  localparam logic [ALUC_W-1:0] ALUC_INC   = 4'd5;
  localparam logic [ALUC_W-1:0] ALUC_EQ    = 4'd6;

  localparam logic [S2_W-1:0] MuxD_fromALU = 2'd0;
  localparam logic [S2_W-1:0] MuxD_fromI   = 2'd1;
  localparam logic [S2_W-1:0] MuxD_fromMem = 2'd2;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_LOADI = 3'd1,
    CLS_ALU   = 3'd2,
    CLS_SETP  = 3'd3,
    CLS_LOAD  = 3'd4,
    CLS_STORE = 3'd5,
    CLS_HALT  = 3'd6
  } op_class_e;

  // Memory ops compute their address through the adder; non-ALU ops default to it too.
  function automatic logic [ALUC_W-1:0] opc_to_aluc(input logic [OPC_W-1:0] opc);
    logic [ALUC_W-1:0] a;
    case (opc)
      ADD:     a = ALUC_ADD;
      MUL:     a = ALUC_MUL;
      MAD:     a = ALUC_MAD;
      LOADC:   a = ALUC_LOADC;
      CLEAR:   a = ALUC_CLEAR;
      INC:     a = ALUC_INC;
      SETP:    a = ALUC_EQ;
      LOAD:    a = ALUC_ADD;
      STORE:   a = ALUC_ADD;
      default: a = ALUC_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/sp_ctrl_seq_if.sv
// Bus between SM fetch / SPCore / memory and the sequencer.
// The master modport is the sequencer side; slave is its environment.
interface sp_ctrl_seq_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              P;
  logic              mem_ack;
  logic [REG_AW-1:0] x;
  logic [REG_AW-1:0] y;
  logic [REG_AW-1:0] z;
  logic [DATA_W-1:0] I;
  logic [3:0]        aluc;
  logic [1:0]        s2;
  logic              reg_we;
  logic              p_we;
  logic              mem_req;
  logic              mem_we;
  logic              busy;
  logic              err;

  modport master (
    input  instr, instr_valid, P, mem_ack,
    output instr_ready, x, y, z, I, aluc, s2, reg_we, p_we, mem_req, mem_we, busy, err
  );

  modport slave (
    output instr, instr_valid, P, mem_ack,
    input  instr_ready, x, y, z, I, aluc, s2, reg_we, p_we, mem_req, mem_we, busy, err
  );
endinterface

// File: rtl/sp_instr_decode.sv
// Combinational opcode decode: ALU op, write-back source and sequencing class.
// Undefined opcodes decode as NOP.
module sp_instr_decode
  import sp_ctrl_seq_pkg::*;
(
  input  logic [OPC_W-1:0]  opc,
  output logic [ALUC_W-1:0] aluc,
  output logic [S2_W-1:0]   s2,
  output op_class_e         cls
);

  // Opcode to ALU op, write-back mux select and op class
  always_comb begin
    aluc = opc_to_aluc(opc);
    s2   = MuxD_fromALU;
    cls  = CLS_NOP;
    case (opc)
      NOP:   cls = CLS_NOP;
      LOADI: begin
        s2  = MuxD_fromI;
        cls = CLS_LOADI;
      end
      ADD, MUL, MAD, LOADC, CLEAR, INC: cls = CLS_ALU;
      SETP:  cls = CLS_SETP;
      LOAD:  begin
        s2  = MuxD_fromMem;
        cls = CLS_LOAD;
      end
      STORE: cls = CLS_STORE;
      HALT:  cls = CLS_HALT;
      default: begin
        s2  = MuxD_fromALU;
        cls = CLS_NOP;
      end
    endcase
  end

endmodule

// File: rtl/sp_ctrl_seq.sv
// Per-SPCore instruction sequencer: accepts one instruction per handshake and
// steps it through EXE, optional MEM wait and WB, driving SPCore controls.
module sp_ctrl_seq
  import sp_ctrl_seq_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input logic          clk,
  input logic          reset_n,
  sp_ctrl_seq_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXE    = 3'd1,
    ST_MEM    = 3'd2,
    ST_WB     = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // Counter holds the index of the current MEM cycle, so the last allowed one is TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e            state_r, state_s;
  op_class_e         cls_r, cls_s, dec_cls_s, acc_cls_s;
  logic [ALUC_W-1:0] dec_aluc_s;
  logic [S2_W-1:0]   dec_s2_s;
  logic              ready_s, accept_s, tmo_hit_s;
  logic              err_r, err_s;
  logic [7:0]        cnt_r;

  logic [REG_AW-1:0] x_r, y_r, z_r;
  logic [DATA_W-1:0] i_r;
  logic [ALUC_W-1:0] aluc_r;
  logic [S2_W-1:0]   s2_r;
  logic              reg_we_r, p_we_r, mem_req_r, mem_we_r;
  logic              reg_we_s, p_we_s, mem_req_s, mem_we_s;

  sp_instr_decode u_decode (
    .opc  (bus.instr[OPC_LSB +: OPC_W]),
    .aluc (dec_aluc_s),
    .s2   (dec_s2_s),
    .cls  (dec_cls_s)
  );

  assign ready_s   = (state_r == ST_IDLE) && !err_r && reset_n;
  assign accept_s  = bus.instr_valid && ready_s;
  assign tmo_hit_s = (state_r == ST_MEM) && (cnt_r == TMO_LAST);

  // A guarded op whose predicate is false at accept retires as a NOP
  always_comb begin
    if (bus.instr[GUARD_BIT] && !bus.P) begin
      acc_cls_s = CLS_NOP;
    end else begin
      acc_cls_s = dec_cls_s;
    end
  end

  // Next-state logic; also tracks the latched op class and sticky timeout error
  always_comb begin
    state_s = state_r;
    cls_s   = cls_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cls_s = acc_cls_s;
          if (acc_cls_s == CLS_HALT) begin
            state_s = ST_HALTED;
          end else begin
            state_s = ST_EXE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXE: begin
        case (cls_r)
          CLS_ALU:   state_s = ST_WB;
          CLS_LOAD:  state_s = bus.mem_ack ? ST_WB : ST_MEM;
          CLS_STORE: state_s = bus.mem_ack ? ST_IDLE : ST_MEM;
          default:   state_s = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          state_s = (cls_r == CLS_LOAD) ? ST_WB : ST_IDLE;
        end else if (tmo_hit_s) begin
          state_s = ST_IDLE;
          err_s   = 1'b1;
        end else begin
          state_s = ST_MEM;
        end
      end
      ST_WB:     state_s = ST_IDLE;
      ST_HALTED: state_s = ST_HALTED;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Enables for the coming cycle, decoded from the next state so they can be registered
  always_comb begin
    reg_we_s  = 1'b0;
    p_we_s    = 1'b0;
    mem_req_s = 1'b0;
    mem_we_s  = 1'b0;
    case (state_s)
      ST_EXE: begin
        reg_we_s  = (cls_s == CLS_LOADI);
        p_we_s    = (cls_s == CLS_SETP);
        mem_req_s = (cls_s == CLS_LOAD) || (cls_s == CLS_STORE);
        mem_we_s  = (cls_s == CLS_STORE);
      end
      ST_MEM: begin
        mem_req_s = 1'b1;
        mem_we_s  = (cls_s == CLS_STORE);
      end
      ST_WB:   reg_we_s = 1'b1;
      default: reg_we_s = 1'b0;
    endcase
  end

  // State, op class, error flag and MEM-cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cls_r   <= CLS_NOP;
      err_r   <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      cls_r   <= cls_s;
      err_r   <= err_s;
      if (state_r == ST_MEM) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= 8'd0;
      end
    end
  end

  // Output registers; operand fields and mux codes are held for the whole op
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      i_r       <= '0;
      aluc_r    <= '0;
      s2_r      <= '0;
      reg_we_r  <= 1'b0;
      p_we_r    <= 1'b0;
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
    end else begin
      reg_we_r  <= reg_we_s;
      p_we_r    <= p_we_s;
      mem_req_r <= mem_req_s;
      mem_we_r  <= mem_we_s;
      if (accept_s) begin
        x_r    <= bus.instr[X_LSB +: REG_AW];
        y_r    <= bus.instr[Y_LSB +: REG_AW];
        z_r    <= bus.instr[Z_LSB +: REG_AW];
        i_r    <= bus.instr[I_LSB +: DATA_W];
        aluc_r <= dec_aluc_s;
        s2_r   <= dec_s2_s;
      end else begin
        x_r    <= x_r;
        y_r    <= y_r;
        z_r    <= z_r;
        i_r    <= i_r;
        aluc_r <= aluc_r;
        s2_r   <= s2_r;
      end
    end
  end

  assign bus.instr_ready = ready_s;
  assign bus.x           = x_r;
  assign bus.y           = y_r;
  assign bus.z           = z_r;
  assign bus.I           = i_r;
  assign bus.aluc        = aluc_r;
  assign bus.s2          = s2_r;
  assign bus.reg_we      = reg_we_r;
  assign bus.p_we        = p_we_r;
  assign bus.mem_req     = mem_req_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.busy        = (state_r != ST_IDLE);
  assign bus.err         = err_r;

endmodule
